// File: rtl/mem_completion_buffer.sv
// -----------------------------------------------------------------------------
// mem_completion_buffer
//
// In-order completion buffer sitting between EX/MEM and write-back. Up to
// DEPTH instructions can be in flight at once, so a load that is waiting on
// the d-cache does not block younger ALU results from entering the buffer.
// D-cache responses arrive in order and complete the oldest pending load.
// The head entry retires to write-back once it is done, one per cycle.
// A combinational forwarding lookup reports the youngest buffered producer of
// a queried register to the hazard controller.
//
// Ports
//   clk, rst_n        clock (rising edge) and asynchronous active-low reset
//   i_valid           enqueue request from EX
//   i_is_mem_access   entry must wait for a d-cache response
//   i_uses_rw         entry writes the register file
//   i_rw_addr         destination register
//   i_alu_result      write data for non-memory entries
//   o_ready           buffer not full; enqueue accepted this cycle
//   i_resp_valid      d-cache response valid
//   i_resp_data       d-cache load data
//   o_wb_valid        head entry retires this cycle
//   o_wb_uses_rw      write-back enable (0 when not retiring)
//   o_wb_rw_addr      write-back register (0 when not retiring)
//   o_wb_rw_data      write-back data (0 when not retiring)
//   i_fwd_addr        register queried by the hazard controller
//   o_fwd_hit         a buffered entry will write i_fwd_addr
//   o_fwd_ready       that entry's data is available
//   o_fwd_data        that entry's data
//   o_count           number of occupied entries
//   o_err             sticky: a response arrived with no eligible load
// -----------------------------------------------------------------------------
module mem_completion_buffer #(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int DEPTH          = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,

  input  logic                        i_valid,
  input  logic                        i_is_mem_access,
  input  logic                        i_uses_rw,
  input  logic [REG_ADDR_WIDTH-1:0]   i_rw_addr,
  input  logic [DATA_WIDTH-1:0]       i_alu_result,
  output logic                        o_ready,

  input  logic                        i_resp_valid,
  input  logic [DATA_WIDTH-1:0]       i_resp_data,

  output logic                        o_wb_valid,
  output logic                        o_wb_uses_rw,
  output logic [REG_ADDR_WIDTH-1:0]   o_wb_rw_addr,
  output logic [DATA_WIDTH-1:0]       o_wb_rw_data,

  input  logic [REG_ADDR_WIDTH-1:0]   i_fwd_addr,
  output logic                        o_fwd_hit,
  output logic                        o_fwd_ready,
  output logic [DATA_WIDTH-1:0]       o_fwd_data,

  output logic [$clog2(DEPTH):0]      o_count,
  output logic                        o_err
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  // ---------------------------------------------------------------------------
  // Entry storage and pointers
  // ---------------------------------------------------------------------------
  logic                      ent_valid   [DEPTH];
  logic                      ent_mem     [DEPTH];
  logic                      ent_done    [DEPTH];
  logic                      ent_uses_rw [DEPTH];
  logic [REG_ADDR_WIDTH-1:0] ent_rw_addr [DEPTH];
  logic [DATA_WIDTH-1:0]     ent_data    [DEPTH];

  logic [PTR_W-1:0] head_q;
  logic [PTR_W-1:0] tail_q;
  logic [CNT_W-1:0] count_q;
  logic             err_q;

  // ---------------------------------------------------------------------------
  // Per-cycle events
  // ---------------------------------------------------------------------------
  logic             full;
  logic             enq;
  logic             retire;
  logic             resp_found;
  logic [PTR_W-1:0] resp_idx;
  logic [PTR_W-1:0] resp_scan_idx;

  assign full   = (count_q == CNT_W'(DEPTH));
  assign enq    = i_valid && !full;
  assign retire = ent_valid[head_q] && ent_done[head_q];

  // Oldest pending load, searched from head. Only state from before the edge
  // is looked at, so a load enqueued this cycle can never take this cycle's
  // response. The retiring head is always done, so it never collides with
  // the response target.
  always_comb begin
    resp_found    = 1'b0;
    resp_idx      = '0;
    resp_scan_idx = '0;
    for (int k = 0; k < DEPTH; k++) begin
      resp_scan_idx = head_q + PTR_W'(k);
      if (!resp_found && ent_valid[resp_scan_idx] &&
          ent_mem[resp_scan_idx] && !ent_done[resp_scan_idx]) begin
        resp_found = 1'b1;
        resp_idx   = resp_scan_idx;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // State update
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < DEPTH; k++) begin
        ent_valid[k]   <= 1'b0;
        ent_mem[k]     <= 1'b0;
        ent_done[k]    <= 1'b0;
        ent_uses_rw[k] <= 1'b0;
        ent_rw_addr[k] <= '0;
        ent_data[k]    <= '0;
      end
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      err_q   <= 1'b0;
    end else begin
      // The tail slot is free whenever enq is set, so it never aliases the
      // retiring head or the response target.
      if (enq) begin
        ent_valid[tail_q]   <= 1'b1;
        ent_mem[tail_q]     <= i_is_mem_access;
        ent_done[tail_q]    <= ~i_is_mem_access;
        ent_uses_rw[tail_q] <= i_uses_rw;
        ent_rw_addr[tail_q] <= i_rw_addr;
        ent_data[tail_q]    <= i_alu_result;
        tail_q              <= tail_q + 1'b1;
      end

      if (i_resp_valid) begin
        if (resp_found) begin
          ent_data[resp_idx] <= i_resp_data;
          ent_done[resp_idx] <= 1'b1;
        end else begin
          err_q <= 1'b1;
        end
      end

      if (retire) begin
        ent_valid[head_q] <= 1'b0;
        head_q            <= head_q + 1'b1;
      end

      count_q <= count_q + CNT_W'(enq) - CNT_W'(retire);
    end
  end

  // ---------------------------------------------------------------------------
  // Write-back port: combinational view of the head entry, zeroed when idle
  // ---------------------------------------------------------------------------
  always_comb begin
    o_wb_valid   = retire;
    o_wb_uses_rw = 1'b0;
    o_wb_rw_addr = '0;
    o_wb_rw_data = '0;
    if (retire) begin
      o_wb_uses_rw = ent_uses_rw[head_q];
      o_wb_rw_addr = ent_rw_addr[head_q];
      o_wb_rw_data = ent_data[head_q];
    end
  end

  // ---------------------------------------------------------------------------
  // Forwarding lookup: scan oldest to youngest so the youngest match wins.
  // Register 0 is never forwarded. The head still counts while retiring,
  // because the register file has not been written yet this cycle.
  // ---------------------------------------------------------------------------
  logic [PTR_W-1:0] fwd_scan_idx;

  always_comb begin
    o_fwd_hit    = 1'b0;
    o_fwd_ready  = 1'b0;
    o_fwd_data   = '0;
    fwd_scan_idx = '0;
    if (i_fwd_addr != '0) begin
      for (int k = 0; k < DEPTH; k++) begin
        fwd_scan_idx = head_q + PTR_W'(k);
        if (ent_valid[fwd_scan_idx] && ent_uses_rw[fwd_scan_idx] &&
            (ent_rw_addr[fwd_scan_idx] == i_fwd_addr)) begin
          o_fwd_hit   = 1'b1;
          o_fwd_ready = ent_done[fwd_scan_idx];
          o_fwd_data  = ent_data[fwd_scan_idx];
        end
      end
    end
  end

  assign o_ready = !full;
  assign o_count = count_q;
  assign o_err   = err_q;

endmodule

// File: tb/tb_mem_completion_buffer.sv
// -----------------------------------------------------------------------------
// tb_mem_completion_buffer
//
// Directed bench for mem_completion_buffer (DEPTH=4). Inputs change 1 ns
// after a rising edge; outputs are checked 1 ns later, well clear of edges.
// -----------------------------------------------------------------------------
module tb_mem_completion_buffer;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int DEPTH = 4;

  logic          clk;
  logic          rst_n;
  logic          i_valid;
  logic          i_is_mem_access;
  logic          i_uses_rw;
  logic [AW-1:0] i_rw_addr;
  logic [DW-1:0] i_alu_result;
  logic          o_ready;
  logic          i_resp_valid;
  logic [DW-1:0] i_resp_data;
  logic          o_wb_valid;
  logic          o_wb_uses_rw;
  logic [AW-1:0] o_wb_rw_addr;
  logic [DW-1:0] o_wb_rw_data;
  logic [AW-1:0] i_fwd_addr;
  logic          o_fwd_hit;
  logic          o_fwd_ready;
  logic [DW-1:0] o_fwd_data;
  logic [2:0]    o_count;
  logic          o_err;

  int n_checks = 0;
  int n_pass   = 0;

  mem_completion_buffer #(
    .DATA_WIDTH(DW), .REG_ADDR_WIDTH(AW), .DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .i_valid(i_valid), .i_is_mem_access(i_is_mem_access),
    .i_uses_rw(i_uses_rw), .i_rw_addr(i_rw_addr),
    .i_alu_result(i_alu_result), .o_ready(o_ready),
    .i_resp_valid(i_resp_valid), .i_resp_data(i_resp_data),
    .o_wb_valid(o_wb_valid), .o_wb_uses_rw(o_wb_uses_rw),
    .o_wb_rw_addr(o_wb_rw_addr), .o_wb_rw_data(o_wb_rw_data),
    .i_fwd_addr(i_fwd_addr), .o_fwd_hit(o_fwd_hit),
    .o_fwd_ready(o_fwd_ready), .o_fwd_data(o_fwd_data),
    .o_count(o_count), .o_err(o_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic idle_inputs();
    i_valid         = 1'b0;
    i_is_mem_access = 1'b0;
    i_uses_rw       = 1'b0;
    i_rw_addr       = '0;
    i_alu_result    = '0;
    i_resp_valid    = 1'b0;
    i_resp_data     = '0;
  endtask

  task automatic drive_enq(input logic mem, input logic [AW-1:0] addr, input logic [DW-1:0] data);
    i_valid         = 1'b1;
    i_is_mem_access = mem;
    i_uses_rw       = 1'b1;
    i_rw_addr       = addr;
    i_alu_result    = data;
  endtask

  task automatic check_wb(input string tag, input logic v, input logic [AW-1:0] addr, input logic [DW-1:0] data);
    check({tag, "_wb_valid"}, 64'(o_wb_valid), 64'(v));
    check({tag, "_wb_uses"},  64'(o_wb_uses_rw), 64'(v));
    check({tag, "_wb_addr"},  64'(o_wb_rw_addr), 64'(addr));
    check({tag, "_wb_data"},  64'(o_wb_rw_data), 64'(data));
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_ready"}, 64'(o_ready), 64'd1);
    check({tag, "_count"}, 64'(o_count), 64'd0);
    check_wb(tag, 1'b0, '0, '0);
    check({tag, "_err"}, 64'(o_err), 64'd0);
    check({tag, "_fwd_hit"}, 64'(o_fwd_hit), 64'd0);
  endtask

  initial begin
    idle_inputs();
    i_fwd_addr = '0;
    rst_n = 1'b0;
    #22;
    // ---- reset state ----
    check_idle("rst");
    rst_n = 1'b1;
    tick();
    check_idle("idle");

    // ---- single ALU op into empty buffer ----
    drive_enq(1'b0, 5'd5, 32'h1234);
    settle();
    check("alu_ready", 64'(o_ready), 64'd1);
    tick();
    idle_inputs();
    settle();
    check_wb("alu", 1'b1, 5'd5, 32'h1234);
    check("alu_count1", 64'(o_count), 64'd1);
    tick();
    check("alu_count0", 64'(o_count), 64'd0);
    check("alu_wb_done", 64'(o_wb_valid), 64'd0);

    // ---- load then younger ALU op, strict ordering ----
    drive_enq(1'b1, 5'd8, 32'h5555);
    tick();
    drive_enq(1'b0, 5'd9, 32'hAA);
    tick();
    idle_inputs();
    i_fwd_addr = 5'd8;
    settle();
    check_wb("ld_wait", 1'b0, '0, '0);
    check("ld_count", 64'(o_count), 64'd2);
    check("ld_fwd_hit", 64'(o_fwd_hit), 64'd1);
    check("ld_fwd_ready", 64'(o_fwd_ready), 64'd0);
    check("ld_fwd_data", 64'(o_fwd_data), 64'd0 + 64'h5555);
    i_resp_valid = 1'b1;
    i_resp_data  = 32'hDEAD;
    settle();
    check("ld_no_comb_retire", 64'(o_wb_valid), 64'd0);
    tick();
    idle_inputs();
    settle();
    check_wb("ld_r8", 1'b1, 5'd8, 32'hDEAD);
    tick();
    check_wb("ld_r9", 1'b1, 5'd9, 32'hAA);
    tick();
    check("ld_count0", 64'(o_count), 64'd0);
    check("ld_err", 64'(o_err), 64'd0);

    // ---- fill with 4 loads (pointers start at 3, so they wrap) ----
    for (int i = 0; i < DEPTH; i++) begin
      drive_enq(1'b1, AW'(10 + i), 32'hF000 + DW'(i));
      tick();
    end
    idle_inputs();
    settle();
    check("full_ready", 64'(o_ready), 64'd0);
    check("full_count", 64'(o_count), 64'd4);
    drive_enq(1'b0, 5'd20, 32'h2020);
    tick();
    idle_inputs();
    i_fwd_addr = 5'd20;
    settle();
    check("full_ignored_count", 64'(o_count), 64'd4);
    check("full_ignored_fwd", 64'(o_fwd_hit), 64'd0);
    for (int i = 0; i < DEPTH; i++) begin
      i_resp_valid = 1'b1;
      i_resp_data  = DW'(i + 1);
      tick();
      check_wb($sformatf("drain%0d", i), 1'b1, AW'(10 + i), DW'(i + 1));
      check($sformatf("drain%0d_count", i), 64'(o_count), 64'(DEPTH - i));
    end
    idle_inputs();
    tick();
    check("drain_count0", 64'(o_count), 64'd0);
    check("drain_ready", 64'(o_ready), 64'd1);
    check("drain_wb_idle", 64'(o_wb_valid), 64'd0);

    // ---- forwarding: load r7, ALU r3=0x10, load r3 ----
    drive_enq(1'b1, 5'd7, 32'h0);
    tick();
    drive_enq(1'b0, 5'd3, 32'h10);
    tick();
    drive_enq(1'b1, 5'd3, 32'h999);
    tick();
    idle_inputs();
    i_fwd_addr = 5'd3;
    settle();
    check("fwd_pend_hit", 64'(o_fwd_hit), 64'd1);
    check("fwd_pend_ready", 64'(o_fwd_ready), 64'd0);
    check("fwd_pend_data", 64'(o_fwd_data), 64'h999);
    i_fwd_addr = 5'd0;
    settle();
    check("fwd_r0_hit", 64'(o_fwd_hit), 64'd0);
    check("fwd_r0_data", 64'(o_fwd_data), 64'd0);
    i_fwd_addr = 5'd4;
    settle();
    check("fwd_miss_hit", 64'(o_fwd_hit), 64'd0);
    i_fwd_addr = 5'd3;
    i_resp_valid = 1'b1;
    i_resp_data  = 32'h70;
    tick();
    settle();
    check("fwd_r7_done_r3_pend", 64'(o_fwd_ready), 64'd0);
    check_wb("fwd_r7", 1'b1, 5'd7, 32'h70);
    i_resp_data = 32'h77;
    tick();
    idle_inputs();
    settle();
    check("fwd_done_hit", 64'(o_fwd_hit), 64'd1);
    check("fwd_done_ready", 64'(o_fwd_ready), 64'd1);
    check("fwd_done_data", 64'(o_fwd_data), 64'h77);
    check_wb("fwd_alu_r3", 1'b1, 5'd3, 32'h10);
    tick();
    check_wb("fwd_ld_r3", 1'b1, 5'd3, 32'h77);
    check("fwd_head_retiring_hit", 64'(o_fwd_hit), 64'd1);
    check("fwd_head_retiring_data", 64'(o_fwd_data), 64'h77);
    tick();
    check("fwd_count0", 64'(o_count), 64'd0);
    check("fwd_gone", 64'(o_fwd_hit), 64'd0);

    // ---- stray response with empty buffer ----
    i_resp_valid = 1'b1;
    i_resp_data  = 32'h1;
    tick();
    idle_inputs();
    settle();
    check("err_empty", 64'(o_err), 64'd1);
    tick();
    check("err_sticky", 64'(o_err), 64'd1);
    rst_n = 1'b0;
    settle();
    check("err_cleared", 64'(o_err), 64'd0);
    rst_n = 1'b1;
    tick();

    // ---- response in same cycle as the only load's enqueue ----
    drive_enq(1'b1, 5'd6, 32'h0);
    i_resp_valid = 1'b1;
    i_resp_data  = 32'hBAD;
    tick();
    idle_inputs();
    settle();
    check("same_cyc_err", 64'(o_err), 64'd1);
    check("same_cyc_count", 64'(o_count), 64'd1);
    check("same_cyc_wb", 64'(o_wb_valid), 64'd0);
    tick();
    check("same_cyc_still_wait", 64'(o_wb_valid), 64'd0);
    i_resp_valid = 1'b1;
    i_resp_data  = 32'h66;
    tick();
    idle_inputs();
    settle();
    check_wb("same_cyc_r6", 1'b1, 5'd6, 32'h66);
    check("same_cyc_err_sticky", 64'(o_err), 64'd1);
    tick();

    // ---- reset mid-traffic ----
    drive_enq(1'b1, 5'd2, 32'h0);
    tick();
    drive_enq(1'b0, 5'd5, 32'h55);
    tick();
    idle_inputs();
    i_fwd_addr = 5'd5;
    settle();
    check("mid_count2", 64'(o_count), 64'd2);
    rst_n = 1'b0;
    settle();
    check_idle("mid_rst");
    rst_n = 1'b1;
    tick();
    tick();
    check_idle("post_rst");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
